event_fifo_v2: RTL

EVENT_FIFO_V2 -- requirements
Module: event_fifo_v2

---
 rtl/event_fifo_pkg.sv | 52 +++++
 rtl/axi4_lite_if.sv | 37 +++
 rtl/fifo_core.sv | 69 ++++++
 rtl/event_fifo_v2.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/event_fifo_pkg.sv
// Shared definitions for the event FIFO: register map, bit positions,
// AXI response codes and the address decoder used by the register file.
package event_fifo_pkg;

    localparam logic [31:0] ADDR_STATUS = 32'h0000_0000;
    localparam logic [31:0] ADDR_COUNT  = 32'h0000_0004;
    localparam logic [31:0] ADDR_THR    = 32'h0000_0008;
    localparam logic [31:0] ADDR_CTRL   = 32'h0000_000C;
    localparam logic [31:0] ADDR_DROPS  = 32'h0000_0010;
    localparam logic [31:0] ADDR_DATA   = 32'h0000_0014;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_REACHED = 3;
    localparam int ST_IRQ_EN  = 4;

    localparam int CT_FLUSH     = 0;
    localparam int CT_CLR_OVF   = 1;
    localparam int CT_CLR_DROPS = 2;
    localparam int CT_IRQ_EN    = 3;

    localparam int DROPS_W = 16;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [2:0] {
        REG_STATUS,
        REG_COUNT,
        REG_THR,
        REG_CTRL,
        REG_DROPS,
        REG_DATA,
        REG_NONE
    } reg_e;

    function automatic reg_e decode_addr(input logic [31:0] addr);
        case (addr)
            ADDR_STATUS: return REG_STATUS;
            ADDR_COUNT:  return REG_COUNT;
            ADDR_THR:    return REG_THR;
            ADDR_CTRL:   return REG_CTRL;
            ADDR_DROPS:  return REG_DROPS;
            ADDR_DATA:   return REG_DATA;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// 32-bit AXI4-Lite bundle (five channels) with master and slave views.
// Ports: none; signals are grouped per channel, modports fix direction.
interface axi4_lite_if;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/fifo_core.sv
// Circular event store with read/write pointers and an occupancy count.
// Ports: aclk/aresetn, push/pop/flush strobes, din/dout, count, empty, full.
module fifo_core #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A push into a full FIFO is still accepted when a pop frees the
    // slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; only entries between the pointers are live.
    always_ff @(posedge aclk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/event_fifo_v2.sv
// Event FIFO with an AXI4-Lite register file, drop counter and level irq.
// Ports: aclk, aresetn, wr_en/data_in (event push), axi (slave), irq.
module event_fifo_v2
    import event_fifo_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 1024,
    parameter int THR_RST = DEPTH / 2
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    axi4_lite_if.slave        axi,
    output logic              irq
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] THR_INIT = CW'(THR_RST);

    logic [CW-1:0]      count;
    logic               empty;
    logic               full;
    logic [DATA_W-1:0]  dout;
    logic               pop;
    logic               flush;
    logic               drop;

    logic               ar_rdy;
    logic               r_vld;
    logic [31:0]        r_data;
    resp_e              r_resp;
    logic               w_rdy;
    logic               b_vld;
    resp_e              b_resp;

    logic [CW-1:0]      thr;
    logic               ovf;
    logic [DROPS_W-1:0] drops;
    logic               irq_en;
    logic               reached;

    logic               ar_hs;
    logic               w_hs;
    reg_e               rd_reg;
    reg_e               wr_reg;
    logic               ctrl_wr;
    logic               wr_ok;
    logic [31:0]        status;
    logic [31:0]        rd_word;
    logic               rd_err;
    logic               unused_wbits;

    fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (wr_en),
        .pop     (pop),
        .flush   (flush),
        .din     (data_in),
        .dout    (dout),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

    assign axi.arready = ar_rdy;
    assign axi.rvalid  = r_vld;
    assign axi.rdata   = r_data;
    assign axi.rresp   = r_resp;
    assign axi.awready = w_rdy;
    assign axi.wready  = w_rdy;
    assign axi.bvalid  = b_vld;
    assign axi.bresp   = b_resp;

    // Writes are always full-word, so strobes and unused data bits drop.
    assign unused_wbits = ^{axi.wstrb, axi.wdata};

    assign ar_hs   = axi.arvalid && ar_rdy;
    assign w_hs    = w_rdy && axi.awvalid && axi.wvalid;
    assign rd_reg  = decode_addr(axi.araddr);
    assign wr_reg  = decode_addr(axi.awaddr);
    assign wr_ok   = (wr_reg == REG_THR) || (wr_reg == REG_CTRL);
    assign ctrl_wr = w_hs && (wr_reg == REG_CTRL);

    assign pop   = ar_hs && (rd_reg == REG_DATA);
    assign flush = ctrl_wr && axi.wdata[CT_FLUSH];

    // A pop on a full FIFO makes room, so the push is not a drop; a flush
    // discards the word outright and is not counted either.
    assign drop = wr_en && full && !pop && !flush;

    assign reached = (count >= thr);
    assign irq     = reached && irq_en;

    always_comb begin
        status             = '0;
        status[ST_EMPTY]   = empty;
        status[ST_FULL]    = full;
        status[ST_OVF]     = ovf;
        status[ST_REACHED] = reached;
        status[ST_IRQ_EN]  = irq_en;
    end

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        case (rd_reg)
            REG_STATUS: rd_word = status;
            REG_COUNT:  rd_word[CW-1:0] = count;
            REG_THR:    rd_word[CW-1:0] = thr;
            REG_CTRL:   rd_word = '0;
            REG_DROPS:  rd_word[DROPS_W-1:0] = drops;
            REG_DATA: begin
                if (!empty) begin
                    rd_word[DATA_W-1:0] = dout;
                end
            end
            default:    rd_err = 1'b1;
        endcase
    end

    // Read channel: arready pulses for one cycle, response holds until rready.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_rdy <= 1'b0;
            r_vld  <= 1'b0;
            r_data <= '0;
            r_resp <= OKAY;
        end else begin
            ar_rdy <= axi.arvalid && !ar_rdy && !r_vld;
            if (ar_hs) begin
                r_vld  <= 1'b1;
                r_data <= rd_word;
                r_resp <= rd_err ? SLVERR : OKAY;
            end else if (r_vld && axi.rready) begin
                r_vld <= 1'b0;
            end
        end
    end

    // Write channel: address and data are accepted together in one cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_rdy  <= 1'b0;
            b_vld  <= 1'b0;
            b_resp <= OKAY;
        end else begin
            w_rdy <= axi.awvalid && axi.wvalid && !w_rdy && !b_vld;
            if (w_hs) begin
                b_vld  <= 1'b1;
                b_resp <= wr_ok ? OKAY : SLVERR;
            end else if (b_vld && axi.bready) begin
                b_vld <= 1'b0;
            end
        end
    end

    // Register file. An explicit clear beats a drop in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            thr    <= THR_INIT;
            ovf    <= 1'b0;
            drops  <= '0;
            irq_en <= 1'b0;
        end else begin
            if (w_hs && (wr_reg == REG_THR)) begin
                thr <= axi.wdata[CW-1:0];
            end
            if (ctrl_wr) begin
                irq_en <= axi.wdata[CT_IRQ_EN];
            end
            if (ctrl_wr && axi.wdata[CT_CLR_OVF]) begin
                ovf <= 1'b0;
            end else if (drop) begin
                ovf <= 1'b1;
            end
            if (ctrl_wr && axi.wdata[CT_CLR_DROPS]) begin
                drops <= '0;
            end else if (drop && (drops != {DROPS_W{1'b1}})) begin
                drops <= drops + 1'b1;
            end
        end
    end

endmodule
